robsdiv: RTL
============

Name: robsdiv

Overview:
- Signed two's-complement sequential divider: 2N-bit dividend ÷ N-bit divisor → N-bit quotient and N-bit remainder.
- Inverse companion to the Robertson's multiplier; a 2N-bit product can be fed back in to recover its operands.
- FSM control unit plus shift/subtract datapath, one quotient bit per clock, with a start/done handshake.

Parameters:
N, 8, operand width. Dividend is 2N bits; divisor, quotient and remainder are N bits each.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs
start  input  1  request a division; sampled only in IDLE
dividend  input  2N  signed dividend; captured on the accepting edge
divisor  input  N  signed divisor; captured on the accepting edge
quotient  output  N  signed quotient; truncated toward zero
remainder  output  N  signed remainder; takes the sign of the dividend (zero if exact)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when results are valid
div_by_zero  output  1  divisor was 0; valid with done, held until next accept
overflow  output  1  quotient does not fit in N signed bits; valid with done, held until next accept

Behaviour:
- Reset values: quotient 0, remainder 0, busy 0, done 0, div_by_zero 0, overflow 0, state IDLE. Reset mid-operation aborts the operation immediately, with no done pulse.
- IDLE:
  - start=1 captures dividend and divisor and moves to LOAD.
  - On that same edge, quotient, remainder and both flags clear.
  - start in any other state is ignored.
- LOAD (1 cycle):
  - Form |dividend| (2N+1-bit safe) and |divisor| (N+1-bit safe). Record sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend).
  - If divisor==0: set div_by_zero, go to DONE.
  - Else if |dividend|[2N-1:N] >= |divisor| (unsigned quotient wider than N bits): set overflow, go to DONE.
  - Else set R (N+1 bits) = |dividend|[2N-1:N], Q = |dividend|[N-1:0], count = N-1, go to ITER.
- ITER (exactly N cycles, restoring algorithm):
  - Shift {R,Q} left by 1.
  - Compute trial = R - |divisor|.
  - If trial >= 0: R = trial and Q[0] = 1. Else Q[0] = 0.
  - count decrements each cycle. After the count==0 iteration, go to FIX.
- FIX (1 cycle), signed range check on the magnitude Q:
  - Positive result: Q >= 2^(N-1) is overflow.
  - Negative result: Q > 2^(N-1) is overflow.
  - On overflow: quotient = 0, remainder = 0, overflow = 1.
  - Otherwise: quotient = sign_q ? -Q : Q, remainder = sign_r ? -R[N-1:0] : R[N-1:0].
  - Go to DONE.
- DONE (1 cycle): done = 1, busy = 1. Next state is IDLE.
- Results and flags hold until the next accepted start or reset.
- Latency:
  - Normal path: done is high in the (N+3)rd cycle after the accepting edge (IDLE→LOAD→N×ITER→FIX→DONE). For N=8, that is 11 cycles.
  - Early-exit path (div_by_zero or LOAD overflow): done is high in the 2nd cycle after the accepting edge. quotient = remainder = 0.
- div_by_zero takes priority over overflow; the two are never both set.
- Minimum start-to-start spacing equals the latency plus 1 cycle for the return to IDLE. start held high in DONE is not seen until IDLE.
- Most-negative cases:
  - dividend = -2^(2N-1) must be handled via the widened magnitude; it overflows in LOAD for any valid divisor.
  - divisor = -2^(N-1) is legal.

Test Plan:
- Basic (N=8): dividend 100, divisor 7, start one cycle → quotient 14 (0x0E), remainder 2; done pulses exactly 11 cycles after the accept edge, for 1 cycle; busy high for 11 cycles.
- Sign combinations:
  - -100/7 → q 0xF2, r 0xFE
  - 100/-7 → q 0xF2, r 0x02
  - -100/-7 → q 0x0E, r 0xFE
  - -98/7 → q 0xF2, r 0x00
- Divide by zero: 1234/0 → div_by_zero 1, overflow 0, q 0, r 0; done 2 cycles after accept.
- Overflow:
  - 0x0800/8 → overflow set in LOAD; done at cycle 2.
  - 16384/128 (divisor 0x80 = -128) → q 0x80, no overflow.
  - 16384/127 → overflow set in FIX; done at cycle 11.
- Round-trip: feed the multiplier product of -37 × 55 (-2035, 0xF80D) with divisor 55 → q 0xDB (-37), r 0. Also -2035/-37 → q 55, r 0.
- Control:
  - Pulse start again at cycle 4 of an operation → ignored; results unchanged.
  - Assert reset at cycle 6 of another operation → all outputs 0, IDLE immediately, no done.
  - A subsequent start completes correctly.

Source files
------------

// File: rtl/robsdiv.sv
// Signed restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// One quotient bit per clock. The divide runs on magnitudes and the signs are applied at the end.
module robsdiv #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic signed [2*N-1:0] dividend,
    input  logic signed [N-1:0]   divisor,
    output logic signed [N-1:0]   quotient,
    output logic signed [N-1:0]   remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic                  overflow
);
    localparam int CNT_W = $clog2(N);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic signed [2*N-1:0] r_dvd;
    logic signed [N-1:0]   r_dvs;
    logic [N-1:0]          r_rem;
    logic [N-1:0]          r_quo;

    logic [2*N:0] w_abs_dvd;
    logic [N:0]   w_abs_dvs;
    logic [N:0]   w_hi;
    logic [N:0]   w_rsh;
    logic         w_ge;
    logic [N-1:0] w_diff;
    logic         w_sign_q;
    logic         w_sign_r;

    // Widened by one bit so that the most-negative operand has a representable magnitude.
    function automatic logic [2*N:0] f_abs_dvd(input logic signed [2*N-1:0] v);
        logic signed [2*N:0] ext;
        ext = {v[2*N-1], v};
        return ext[2*N] ? -ext : ext;
    endfunction

    function automatic logic [N:0] f_abs_dvs(input logic signed [N-1:0] v);
        logic signed [N:0] ext;
        ext = {v[N-1], v};
        return ext[N] ? -ext : ext;
    endfunction

    // A negative quotient can reach -2^(N-1), but a positive one cannot reach +2^(N-1).
    function automatic logic f_q_ovf(input logic [N-1:0] q, input logic neg);
        return neg ? (q > {1'b1, {(N-1){1'b0}}}) : q[N-1];
    endfunction

    assign w_abs_dvd = f_abs_dvd(r_dvd);
    assign w_abs_dvs = f_abs_dvs(r_dvs);
    assign w_hi      = w_abs_dvd[2*N:N];
    assign w_sign_q  = r_dvd[2*N-1] ^ r_dvs[N-1];
    assign w_sign_r  = r_dvd[2*N-1];
    assign w_rsh     = {r_rem, r_quo[N-1]};
    assign w_ge      = (w_rsh >= w_abs_dvs);
    // Only used when w_ge holds; the difference is then below |divisor|, so N bits are enough.
    assign w_diff    = w_rsh[N-1:0] - w_abs_dvs[N-1:0];

    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: if (start) begin
                r_dvd <= dividend;
                r_dvs <= divisor;
            end
            S_LOAD: begin
                r_rem <= w_hi[N-1:0];
                r_quo <= w_abs_dvd[N-1:0];
            end
            S_ITER: begin
                r_rem <= w_ge ? w_diff : w_rsh[N-1:0];
                r_quo <= {r_quo[N-2:0], w_ge};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_state     <= S_LOAD;
                    busy        <= 1'b1;
                    quotient    <= '0;
                    remainder   <= '0;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                end
                S_LOAD: begin
                    if (w_abs_dvs == '0) begin
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_hi >= w_abs_dvs) begin
                        overflow <= 1'b1;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt   <= CNT_W'(N - 1);
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (f_q_ovf(r_quo, w_sign_q)) begin
                        overflow <= 1'b1;
                    end else begin
                        quotient  <= w_sign_q ? -r_quo : r_quo;
                        remainder <= w_sign_r ? -r_rem : r_rem;
                    end
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
